// File: rtl/text_console_pkg.sv
// text_console_pkg: shared state encoding, register map and control codes
// for the text console. TEXT_CONSOLE_SCROLL_EN adds the scroll states.
package text_console_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        CLEAR     = 3'd2
`ifdef TEXT_CONSOLE_SCROLL_EN
        ,
        SCRL_RD   = 3'd3,
        SCRL_WR   = 3'd4,
        SCRL_FILL = 3'd5
`endif
    } state_e;

    // register select values on ADDR
    localparam logic [1:0] REG_CHAR = 2'd0;
    localparam logic [1:0] REG_CMD  = 2'd1;
    localparam logic [1:0] REG_CURX = 2'd2;
    localparam logic [1:0] REG_CURY = 2'd3;

    // character and command codes
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] BS        = 8'h08;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

endpackage

// File: rtl/tc_charbuf.sv
// tc_charbuf: COLS*ROWS x 8 character store. One engine port (write plus
// registered read) and one registered read-only display port. Contents are
// never reset; only the display output register is.
module tc_charbuf
    import text_console_pkg::*;
#(
    parameter int         COLS = 80,
    parameter int         ROWS = 60,
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic                      CLK,
    input  logic                      RESETB,
    input  logic                      i_eng_we,
    input  logic [$clog2(COLS*ROWS)-1:0] i_eng_addr,
    input  logic [7:0]                i_eng_wdata,
    output logic [7:0]                o_eng_rdata,
    input  logic [$clog2(COLS)-1:0]   i_disp_col,
    input  logic [$clog2(ROWS)-1:0]   i_disp_row,
    output logic [7:0]                o_disp_char
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    logic [7:0]    r_mem [CELLS];
    logic [7:0]    r_eng_rdata;
    logic [7:0]    r_disp_char;
    logic          w_disp_oob;
    logic [AW-1:0] w_disp_addr;

    // display coordinates outside the buffer map to a safe index and read FILL
    always_comb begin
        w_disp_oob = (int'(i_disp_col) >= COLS) || (int'(i_disp_row) >= ROWS);
        if (w_disp_oob) begin
            w_disp_addr = '0;
        end else begin
            w_disp_addr = AW'(i_disp_row) * AW'(COLS) + AW'(i_disp_col);
        end
    end

    // engine write and registered engine read (old data on same-cycle write)
    always_ff @(posedge CLK) begin
        if (i_eng_we) begin
            r_mem[i_eng_addr] <= i_eng_wdata;
        end
        r_eng_rdata <= r_mem[i_eng_addr];
    end

    // registered display read, cleared by reset
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            r_disp_char <= 8'h00;
        end else if (w_disp_oob) begin
            r_disp_char <= FILL;
        end else begin
            r_disp_char <= r_mem[w_disp_addr];
        end
    end

    assign o_eng_rdata = r_eng_rdata;
    assign o_disp_char = r_disp_char;

endmodule

// File: rtl/text_console.sv
// text_console: register-driven character console with cursor, clear engine
// and line advance. Define TEXT_CONSOLE_SCROLL_EN to scroll the buffer on a
// line advance from the last row; otherwise the cursor wraps to row 0.
module text_console
    import text_console_pkg::*;
#(
    parameter int         COLS = 80,
    parameter int         ROWS = 60,
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic                    CLK,
    input  logic                    RESETB,
    input  logic                    WE,
    input  logic [1:0]              ADDR,
    input  logic [7:0]              DATA,
    output logic                    BUSY,
    output logic                    OVERRUN,
    output logic [$clog2(COLS)-1:0] CUR_X,
    output logic [$clog2(ROWS)-1:0] CUR_Y,
    input  logic [$clog2(COLS)-1:0] DISP_COL,
    input  logic [$clog2(ROWS)-1:0] DISP_ROW,
    output logic [7:0]              DISP_CHAR
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int AW = $clog2(COLS * ROWS);
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [YW-1:0] Y_SCR = YW'(ROWS - 2);
`endif

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_addr, w_addr_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic [XW-1:0] r_cx, w_cx_nxt, r_col, w_col_nxt, w_col_sel;
    logic [YW-1:0] r_cy, w_cy_nxt, r_row, w_row_nxt, w_row_sel;
    logic          r_ovr, w_ovr_nxt, w_lf, w_eng_we, w_mem_we;
    logic [AW-1:0] w_eng_addr;
    logic [7:0]    w_eng_wdata, w_eng_rdata;

    // next-state, cursor and buffer-access decode
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_lf        = 1'b0;
        w_eng_we    = 1'b0;
        w_row_sel   = r_cy;
        w_col_sel   = r_cx;
        // scroll copies reuse the word read on the previous cycle
        w_eng_wdata = w_eng_rdata;

        if (WE && (r_state != IDLE)) begin
            w_ovr_nxt = 1'b1;
        end else begin
            w_ovr_nxt = r_ovr;
        end

        case (r_state)
            IDLE: begin
                if (WE) begin
                    w_addr_nxt  = ADDR;
                    w_data_nxt  = DATA;
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: begin
                w_state_nxt = IDLE;
                case (r_addr)
                    REG_CHAR: begin
                        if (r_data == CR) begin
                            w_cx_nxt = '0;
                        end else if (r_data == LF) begin
                            w_lf = 1'b1;
                        end else if (r_data == BS) begin
                            if (r_cx != '0) begin
                                w_cx_nxt    = r_cx - XW'(1);
                                w_col_sel   = r_cx - XW'(1);
                                w_eng_we    = 1'b1;
                                w_eng_wdata = FILL;
                            end else begin
                                w_cx_nxt = r_cx;
                            end
                        end else begin
                            w_eng_we    = 1'b1;
                            w_eng_wdata = r_data;
                            if (r_cx == X_MAX) begin
                                w_cx_nxt = '0;
                                w_lf     = 1'b1;
                            end else begin
                                w_cx_nxt = r_cx + XW'(1);
                            end
                        end
                        if (w_lf) begin
                            if (r_cy != Y_MAX) begin
                                w_cy_nxt = r_cy + YW'(1);
                            end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                                w_state_nxt = SCRL_RD;
                                w_row_nxt   = '0;
                                w_col_nxt   = '0;
`else
                                w_cy_nxt = '0;
`endif
                            end
                        end else begin
                            w_cy_nxt = r_cy;
                        end
                    end
                    REG_CMD: begin
                        if (r_data == CMD_CLEAR) begin
                            w_state_nxt = CLEAR;
                            w_row_nxt   = '0;
                            w_col_nxt   = '0;
                        end else if (r_data == CMD_HOME) begin
                            w_cx_nxt = '0;
                            w_cy_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                    REG_CURX: begin
                        if (int'(r_data) >= COLS) begin
                            w_cx_nxt = X_MAX;
                        end else begin
                            w_cx_nxt = XW'(r_data);
                        end
                    end
                    REG_CURY: begin
                        if (int'(r_data) >= ROWS) begin
                            w_cy_nxt = Y_MAX;
                        end else begin
                            w_cy_nxt = YW'(r_data);
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
            CLEAR: begin
                w_eng_we    = 1'b1;
                w_eng_wdata = FILL;
                w_row_sel   = r_row;
                w_col_sel   = r_col;
                if (r_col == X_MAX) begin
                    w_col_nxt = '0;
                    if (r_row == Y_MAX) begin
                        w_state_nxt = IDLE;
                        w_cx_nxt    = '0;
                        w_cy_nxt    = '0;
                        w_ovr_nxt   = 1'b0;
                    end else begin
                        w_row_nxt = r_row + YW'(1);
                    end
                end else begin
                    w_col_nxt = r_col + XW'(1);
                end
            end
`ifdef TEXT_CONSOLE_SCROLL_EN
            SCRL_RD: begin
                w_row_sel   = r_row + YW'(1);
                w_col_sel   = r_col;
                w_state_nxt = SCRL_WR;
            end
            SCRL_WR: begin
                w_eng_we  = 1'b1;
                w_row_sel = r_row;
                w_col_sel = r_col;
                if (r_col == X_MAX) begin
                    w_col_nxt = '0;
                    if (r_row == Y_SCR) begin
                        w_row_nxt   = Y_MAX;
                        w_state_nxt = SCRL_FILL;
                    end else begin
                        w_row_nxt   = r_row + YW'(1);
                        w_state_nxt = SCRL_RD;
                    end
                end else begin
                    w_col_nxt   = r_col + XW'(1);
                    w_state_nxt = SCRL_RD;
                end
            end
            SCRL_FILL: begin
                w_eng_we    = 1'b1;
                w_eng_wdata = FILL;
                w_row_sel   = r_row;
                w_col_sel   = r_col;
                if (r_col == X_MAX) begin
                    w_col_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_col_nxt = r_col + XW'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            r_state <= IDLE;
            r_addr  <= 2'd0;
            r_data  <= 8'h00;
            r_cx    <= '0;
            r_cy    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // a reset edge abandons the operation without touching the buffer
    assign w_mem_we   = w_eng_we & RESETB;
    assign w_eng_addr = AW'(w_row_sel) * AW'(COLS) + AW'(w_col_sel);

    tc_charbuf #(
        .COLS (COLS),
        .ROWS (ROWS),
        .FILL (FILL)
    ) u_charbuf (
        .CLK         (CLK),
        .RESETB      (RESETB),
        .i_eng_we    (w_mem_we),
        .i_eng_addr  (w_eng_addr),
        .i_eng_wdata (w_eng_wdata),
        .o_eng_rdata (w_eng_rdata),
        .i_disp_col  (DISP_COL),
        .i_disp_row  (DISP_ROW),
        .o_disp_char (DISP_CHAR)
    );

    assign BUSY    = (r_state != IDLE);
    assign OVERRUN = r_ovr;
    assign CUR_X   = r_cx;
    assign CUR_Y   = r_cy;

endmodule

// File: tb/tb_text_console.sv
// tb_text_console: randomized and directed checks of text_console (80x60)
// against a behavioural buffer/cursor model. Follows TEXT_CONSOLE_SCROLL_EN.
module tb_text_console;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 60;
    localparam int         CELLS = COLS * ROWS;
    localparam logic [7:0] FILL  = 8'h00;
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESETB = 1'b0;
    logic       WE = 1'b0;
    logic [1:0] ADDR = 2'd0;
    logic [7:0] DATA = 8'h00;
    logic       BUSY, OVERRUN;
    logic [6:0] CUR_X;
    logic [5:0] CUR_Y;
    logic [6:0] DISP_COL = 7'd0;
    logic [5:0] DISP_ROW = 6'd0;
    logic [7:0] DISP_CHAR;

    int total = 0;
    int bad = 0;
    logic [7:0] mdl_mem [CELLS];
    int mx, my, n_scroll;

    always #5 CLK = ~CLK;

    text_console #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
        .CLK(CLK), .RESETB(RESETB), .WE(WE), .ADDR(ADDR), .DATA(DATA),
        .BUSY(BUSY), .OVERRUN(OVERRUN), .CUR_X(CUR_X), .CUR_Y(CUR_Y),
        .DISP_COL(DISP_COL), .DISP_ROW(DISP_ROW), .DISP_CHAR(DISP_CHAR)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    task automatic model_advance(output int extra);
        extra = 0;
        if (my < ROWS - 1) begin
            my = my + 1;
        end else if (SCROLL) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    mdl_mem[r*COLS + c] = mdl_mem[(r+1)*COLS + c];
            for (int c = 0; c < COLS; c++) mdl_mem[(ROWS-1)*COLS + c] = FILL;
            n_scroll = n_scroll + 1;
            extra = 2*(ROWS-1)*COLS + COLS;
        end else begin
            my = 0;
        end
    endtask

    task automatic model_op(input logic [1:0] a, input logic [7:0] d, output int busy);
        int e;
        busy = 1;
        case (a)
            2'd0: begin
                if (d == 8'h0D) mx = 0;
                else if (d == 8'h0A) begin model_advance(e); busy += e; end
                else if (d == 8'h08) begin
                    if (mx > 0) begin mx = mx - 1; mdl_mem[my*COLS + mx] = FILL; end
                end else begin
                    mdl_mem[my*COLS + mx] = d;
                    if (mx == COLS - 1) begin mx = 0; model_advance(e); busy += e; end
                    else mx = mx + 1;
                end
            end
            2'd1: begin
                if (d == 8'h01) begin
                    for (int i = 0; i < CELLS; i++) mdl_mem[i] = FILL;
                    mx = 0; my = 0; busy += CELLS;
                end else if (d == 8'h02) begin
                    mx = 0; my = 0;
                end
            end
            2'd2: mx = (int'(d) >= COLS) ? COLS - 1 : int'(d);
            default: my = (int'(d) >= ROWS) ? ROWS - 1 : int'(d);
        endcase
    endtask

    // ---------------- stimulus / observation ----------------
    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK); WE = 1'b1; ADDR = a; DATA = d;
        @(negedge CLK); WE = 1'b0;
    endtask

    task automatic exec_op(input logic [1:0] a, input logic [7:0] d, output int got_busy);
        do_write(a, d);
        got_busy = 0;
        while (BUSY === 1'b1 && got_busy < 20000) begin
            got_busy++;
            @(negedge CLK);
        end
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        @(negedge CLK); DISP_ROW = 6'(r); DISP_COL = 7'(c);
        @(negedge CLK); v = DISP_CHAR;
    endtask

    task automatic scan_buffer(output int nmis, output int first_idx, output logic [7:0] first_got);
        nmis = 0; first_idx = -1; first_got = 8'h00;
        for (int i = 0; i <= CELLS; i++) begin
            @(negedge CLK);
            if (i > 0 && DISP_CHAR !== mdl_mem[i-1]) begin
                if (nmis == 0) begin first_idx = i - 1; first_got = DISP_CHAR; end
                nmis++;
            end
            if (i < CELLS) begin DISP_ROW = 6'(i / COLS); DISP_COL = 7'(i % COLS); end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RESETB = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
        total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", OVERRUN); end
        total++; if (CUR_X !== 7'd0) begin bad++; $display("FAIL reset_curx got=%0d want=0", CUR_X); end
        total++; if (CUR_Y !== 6'd0) begin bad++; $display("FAIL reset_cury got=%0d want=0", CUR_Y); end
        total++; if (DISP_CHAR !== 8'h00) begin bad++; $display("FAIL reset_disp got=%h want=00", DISP_CHAR); end
        RESETB = 1'b1;
        mx = 0; my = 0; n_scroll = 0;
    endtask

    task automatic test_overrun_clear;
        int eb, gb, nm, fi;
        logic [7:0] fg;
        @(negedge CLK); WE = 1'b1; ADDR = 2'd0; DATA = 8'h5A;
        @(negedge CLK); DATA = 8'h5B;
        @(negedge CLK); WE = 1'b0;
        model_op(2'd0, 8'h5A, eb);
        total++; if (OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", OVERRUN); end
        total++; if (CUR_X !== 7'(mx)) begin bad++; $display("FAIL overrun_drop_curx got=%0d want=%0d", CUR_X, mx); end
        model_op(2'd1, 8'h01, eb);
        exec_op(2'd1, 8'h01, gb);
        total++; if (gb !== eb) begin bad++; $display("FAIL clear_busy got=%0d want=%0d", gb, eb); end
        total++; if (OVERRUN !== 1'b0) begin bad++; $display("FAIL clear_overrun got=%b want=0", OVERRUN); end
        total++; if (CUR_X !== 7'd0 || CUR_Y !== 6'd0) begin bad++; $display("FAIL clear_cursor got=%0d,%0d want=0,0", CUR_X, CUR_Y); end
        scan_buffer(nm, fi, fg);
        total++; if (nm !== 0) begin bad++; $display("FAIL clear_buffer got=%0d bad cells (first %0d=%h) want=0", nm, fi, fg); end
    endtask

    task automatic test_char;
        int eb;
        logic [7:0] v;
        model_op(2'd0, 8'h41, eb);
        @(negedge CLK); DISP_ROW = 6'd0; DISP_COL = 7'd0; WE = 1'b1; ADDR = 2'd0; DATA = 8'h41;
        @(negedge CLK); WE = 1'b0;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL char_busy_hi got=%b want=1", BUSY); end
        @(negedge CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL char_busy_lo got=%b want=0", BUSY); end
        total++; if (DISP_CHAR !== FILL) begin bad++; $display("FAIL char_rdw_old got=%h want=%h", DISP_CHAR, FILL); end
        total++; if (CUR_X !== 7'(mx)) begin bad++; $display("FAIL char_curx got=%0d want=%0d", CUR_X, mx); end
        @(negedge CLK); v = DISP_CHAR;
        total++; if (v !== mdl_mem[0]) begin bad++; $display("FAIL char_cell got=%h want=%h", v, mdl_mem[0]); end
    endtask

    task automatic test_wrap;
        int eb, gb;
        logic [7:0] v;
        model_op(2'd2, 8'd79, eb); exec_op(2'd2, 8'd79, gb);
        model_op(2'd0, 8'h42, eb); exec_op(2'd0, 8'h42, gb);
        total++; if (gb !== eb) begin bad++; $display("FAIL wrap_busy got=%0d want=%0d", gb, eb); end
        total++; if (CUR_X !== 7'(mx) || CUR_Y !== 6'(my)) begin bad++; $display("FAIL wrap_cursor got=%0d,%0d want=%0d,%0d", CUR_X, CUR_Y, mx, my); end
        read_cell(0, 79, v);
        total++; if (v !== mdl_mem[79]) begin bad++; $display("FAIL wrap_cell got=%h want=%h", v, mdl_mem[79]); end
    endtask

    task automatic test_edit;
        logic [1:0] ta [12] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        logic [7:0] td [12] = '{8'd4, 8'd2, 8'h43, 8'h08, 8'd0, 8'h08, 8'd33, 8'h0D, 8'h02, 8'h7F, 8'd200, 8'd200};
        int eb, gb;
        logic [7:0] v;
        for (int i = 0; i < 12; i++) begin
            model_op(ta[i], td[i], eb);
            exec_op(ta[i], td[i], gb);
            total++; if (gb !== eb || CUR_X !== 7'(mx) || CUR_Y !== 6'(my)) begin
                bad++; $display("FAIL edit_%0d got=busy%0d,%0d,%0d want=busy%0d,%0d,%0d", i, gb, CUR_X, CUR_Y, eb, mx, my);
            end
        end
        read_cell(2, 4, v);
        total++; if (v !== mdl_mem[2*COLS + 4]) begin bad++; $display("FAIL edit_bs_cell got=%h want=%h", v, mdl_mem[2*COLS+4]); end
    endtask

    task automatic test_random;
        int sel, eb, gb, nm, fi, r, c;
        logic [1:0] a;
        logic [7:0] d, v, fg;
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      begin a = 2'd0; d = 8'($urandom_range(32, 126)); end
            else if (sel < 50) begin a = 2'd0; d = 8'h0D; end
            else if (sel < 56) begin a = 2'd0; d = 8'h0A; end
            else if (sel < 66) begin a = 2'd0; d = 8'h08; end
            else if (sel < 80) begin a = 2'd2; d = 8'($urandom_range(0, 100)); end
            else if (sel < 92) begin a = 2'd3; d = 8'($urandom_range(0, ROWS + 3)); end
            else               begin a = 2'd1; d = 8'($urandom_range(2, 255)); end
            if (n_scroll >= 2 && my == ROWS - 1 && a == 2'd0 &&
                (d == 8'h0A || (mx == COLS - 1 && d != 8'h0D && d != 8'h08))) d = 8'h0D;
            model_op(a, d, eb);
            exec_op(a, d, gb);
            total++; if (gb !== eb) begin bad++; $display("FAIL rnd_busy op%0d a=%0d d=%h got=%0d want=%0d", i, a, d, gb, eb); end
            total++; if (CUR_X !== 7'(mx) || CUR_Y !== 6'(my)) begin
                bad++; $display("FAIL rnd_cursor op%0d a=%0d d=%h got=%0d,%0d want=%0d,%0d", i, a, d, CUR_X, CUR_Y, mx, my);
            end
            if (i % 10 == 9) begin
                r = $urandom_range(0, 3); c = $urandom_range(0, COLS - 1);
                read_cell(r, c, v);
                total++; if (v !== mdl_mem[r*COLS + c]) begin bad++; $display("FAIL rnd_cell (%0d,%0d) got=%h want=%h", r, c, v, mdl_mem[r*COLS+c]); end
            end
        end
        scan_buffer(nm, fi, fg);
        total++; if (nm !== 0) begin bad++; $display("FAIL rnd_buffer got=%0d bad cells (first %0d=%h) want=0", nm, fi, fg); end
    endtask

    task automatic test_oob;
        int eb, gb;
        logic [7:0] v;
        model_op(2'd2, 8'd20, eb); exec_op(2'd2, 8'd20, gb);
        model_op(2'd3, 8'd1, eb);  exec_op(2'd3, 8'd1, gb);
        model_op(2'd0, 8'h77, eb); exec_op(2'd0, 8'h77, gb);
        read_cell(0, 100, v);
        total++; if (v !== FILL) begin bad++; $display("FAIL oob_col got=%h want=%h", v, FILL); end
        read_cell(62, 0, v);
        total++; if (v !== FILL) begin bad++; $display("FAIL oob_row got=%h want=%h", v, FILL); end
    endtask

    task automatic test_lastrow;
        int eb, gb, nm, fi;
        logic [7:0] fg;
        model_op(2'd3, 8'(ROWS - 1), eb); exec_op(2'd3, 8'(ROWS - 1), gb);
        model_op(2'd0, 8'h0A, eb); exec_op(2'd0, 8'h0A, gb);
        total++; if (gb !== eb) begin bad++; $display("FAIL lastrow_busy got=%0d want=%0d", gb, eb); end
        total++; if (CUR_Y !== 6'(my) || CUR_X !== 7'(mx)) begin bad++; $display("FAIL lastrow_cursor got=%0d,%0d want=%0d,%0d", CUR_X, CUR_Y, mx, my); end
        scan_buffer(nm, fi, fg);
        total++; if (nm !== 0) begin bad++; $display("FAIL lastrow_buffer got=%0d bad cells (first %0d=%h) want=0", nm, fi, fg); end
    endtask

    task automatic test_reset_mid_clear;
        int eb, gb, nm, fi;
        logic [7:0] fg;
        model_op(2'd3, 8'd1, eb);  exec_op(2'd3, 8'd1, gb);
        model_op(2'd2, 8'd18, eb); exec_op(2'd2, 8'd18, gb);
        model_op(2'd0, 8'h66, eb); exec_op(2'd0, 8'h66, gb);
        model_op(2'd0, 8'h55, eb); exec_op(2'd0, 8'h55, gb);
        do_write(2'd1, 8'h01);
        repeat (100) @(negedge CLK);
        RESETB = 1'b0;
        @(negedge CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL midclr_busy got=%b want=0", BUSY); end
        total++; if (CUR_X !== 7'd0 || CUR_Y !== 6'd0) begin bad++; $display("FAIL midclr_cursor got=%0d,%0d want=0,0", CUR_X, CUR_Y); end
        total++; if (DISP_CHAR !== 8'h00 || OVERRUN !== 1'b0) begin bad++; $display("FAIL midclr_outputs got=%h,%b want=00,0", DISP_CHAR, OVERRUN); end
        RESETB = 1'b1;
        for (int i = 0; i < 99; i++) mdl_mem[i] = FILL;
        mx = 0; my = 0;
        scan_buffer(nm, fi, fg);
        total++; if (nm !== 0) begin bad++; $display("FAIL midclr_buffer got=%0d bad cells (first %0d=%h) want=0", nm, fi, fg); end
    endtask

    initial begin
        test_reset();
        test_overrun_clear();
        test_char();
        test_wrap();
        test_edit();
        test_random();
        test_oob();
        test_lastrow();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
